// File: rtl/riscv_lsu.sv
// riscv_lsu: RISC-V load/store unit with a single outstanding memory access.
//
// Ports
//   clk, rst              single rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_is_load           1 = load, 0 = store
//   req_funct3            RISC-V load/store funct3 (size + signedness)
//   req_addr, req_wdata   byte address and right-aligned store data
//   resp_valid            one-cycle completion pulse, no backpressure
//   resp_rdata            extended load data (0 for stores and errors)
//   resp_err              00 ok, 01 misaligned, 10 timeout, 11 illegal funct3
//   mem_req..mem_wdata    memory request, held stable while waiting for ack
//   mem_ack, mem_rdata    memory completion and read data
//
// Each byte lane is handled by a riscv_lsu_lane instance: it computes its
// byte enable, its replicated write byte and its extended read byte.

module riscv_lsu_lane #(
   parameter int NUM_LANES = 4,
   parameter int OFFW      = 2,
   parameter int LANE      = 0
) (
   input  logic [OFFW-1:0]           offset,
   input  logic [3:0]                size_bytes,
   input  logic [NUM_LANES-1:0][7:0] wdata,
   input  logic [7:0]                rsh_byte,
   input  logic                      ext_bit,
   output logic                      be,
   output logic [7:0]                wbyte,
   output logic [7:0]                rbyte
);
   int off_i;
   int sz_i;

   always_comb begin
      off_i = int'(offset);
      sz_i  = int'(size_bytes);
      be    = (LANE >= off_i) && (LANE < off_i + sz_i);
      // size is a power of two, so lane modulo size is a mask
      wbyte = 8'h00;
      for (int j = 0; j < NUM_LANES; j++)
         if (j == (LANE & (sz_i - 1))) wbyte = wdata[j];
      rbyte = (LANE < sz_i) ? rsh_byte : {8{ext_bit}};
   end
endmodule

module riscv_lsu #(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_is_load,
   input  logic [2:0]        req_funct3,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_rdata,
   output logic [1:0]        resp_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN/8-1:0] mem_be,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_ack,
   input  logic [XLEN-1:0]   mem_rdata
);
   localparam int NUM_LANES = XLEN / 8;
   localparam int OFFW      = $clog2(NUM_LANES);
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   typedef struct packed {
      logic            is_load;
      logic [2:0]      funct3;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
   } lsu_req_t;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t   state, state_nxt;
   lsu_req_t req_q;
   logic [1:0]      err_q;
   logic [XLEN-1:0] rdata_q;
   logic [7:0]      tmo_cnt;

   logic accept, ack_hit, tmo_hit, busy;
   logic illegal, misaligned;
   logic [3:0]      in_size;
   logic [OFFW-1:0] in_mask;

   logic [OFFW-1:0]           q_off;
   logic [3:0]                q_size;
   logic [NUM_LANES-1:0][7:0] rd_shift;
   logic [NUM_LANES-1:0][7:0] wd_lanes;
   logic                      sign_bit, ext_bit;
   logic [NUM_LANES-1:0]      be_v;
   logic [NUM_LANES-1:0][7:0] wdata_v;
   logic [NUM_LANES-1:0][7:0] rdata_v;

   // ---------------- request decode (incoming fields) ----------------
   always_comb begin
      illegal = 1'b1;
      if (req_is_load) begin
         case (req_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal = 1'b0;
            3'b011, 3'b110:                         illegal = (XLEN != 64);
            default:                                illegal = 1'b1;
         endcase
      end else begin
         case (req_funct3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b011:                 illegal = (XLEN != 64);
            default:                illegal = 1'b1;
         endcase
      end
   end

   assign in_size    = 4'd1 << req_funct3[1:0];
   // an 8-byte size on a 32-bit unit truncates here, but it is illegal anyway
   assign in_mask    = OFFW'(in_size - 4'd1);
   assign misaligned = |(req_addr[OFFW-1:0] & in_mask);

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      ack_hit   = 1'b0;
      tmo_hit   = 1'b0;
      case (state)
         IDLE: if (req_valid) begin
            accept    = 1'b1;
            state_nxt = (illegal || misaligned) ? RESP : BUSY;
         end
         BUSY: begin
            // ack wins over a timeout in the same cycle
            if (mem_ack) begin
               ack_hit   = 1'b1;
               state_nxt = RESP;
            end else if (tmo_cnt == TMO_LAST) begin
               tmo_hit   = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         req_q   <= '0;
         err_q   <= 2'b00;
         rdata_q <= '0;
         tmo_cnt <= 8'd0;
      end else begin
         if (accept) begin
            req_q.is_load <= req_is_load;
            req_q.funct3  <= req_funct3;
            req_q.addr    <= req_addr;
            req_q.wdata   <= req_wdata;
            err_q         <= illegal ? 2'b11 : (misaligned ? 2'b01 : 2'b00);
            rdata_q       <= '0;
            tmo_cnt       <= 8'd0;
         end
         if (ack_hit) begin
            err_q   <= 2'b00;
            rdata_q <= req_q.is_load ? rdata_v : '0;
         end else if (tmo_hit) begin
            err_q   <= 2'b10;
            rdata_q <= '0;
            tmo_cnt <= tmo_cnt + 8'd1;
         end else if (busy) begin
            tmo_cnt <= tmo_cnt + 8'd1;
         end
      end
   end

   // ---------------- lane datapath (registered request) ----------------
   assign q_off    = req_q.addr[OFFW-1:0];
   assign q_size   = 4'd1 << req_q.funct3[1:0];
   assign rd_shift = mem_rdata >> {q_off, 3'b000};
   assign wd_lanes = req_q.wdata;

   // sign bit is the top bit of the highest byte of the access
   always_comb begin
      sign_bit = 1'b0;
      for (int j = 0; j < NUM_LANES; j++)
         if (j == int'(q_size) - 1) sign_bit = rd_shift[j][7];
   end
   assign ext_bit = sign_bit & ~req_q.funct3[2];

   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      riscv_lsu_lane #(
         .NUM_LANES (NUM_LANES),
         .OFFW      (OFFW),
         .LANE      (gi)
      ) u_lane (
         .offset     (q_off),
         .size_bytes (q_size),
         .wdata      (wd_lanes),
         .rsh_byte   (rd_shift[gi]),
         .ext_bit    (ext_bit),
         .be         (be_v[gi]),
         .wbyte      (wdata_v[gi]),
         .rbyte      (rdata_v[gi])
      );
   end

   // ---------------- outputs ----------------
   // memory side is driven from the registered request, so it is stable
   // for the whole of BUSY and reads as zero everywhere else
   assign busy       = (state == BUSY);
   assign req_ready  = (state == IDLE);
   assign mem_req    = busy;
   assign mem_we     = busy & ~req_q.is_load;
   assign mem_addr   = busy ? {req_q.addr[XLEN-1:OFFW], {OFFW{1'b0}}} : '0;
   assign mem_be     = busy ? be_v : '0;
   assign mem_wdata  = busy ? wdata_v : '0;
   assign resp_valid = (state == RESP);
   assign resp_err   = resp_valid ? err_q : 2'b00;
   assign resp_rdata = resp_valid ? rdata_q : '0;
endmodule

// File: tb/tb_riscv_lsu.sv
module tb_riscv_lsu;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // 32-bit unit, short timeout
   logic        req_valid = 0, req_ready, req_is_load = 0;
   logic [2:0]  req_funct3 = 0;
   logic [31:0] req_addr = 0, req_wdata = 0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_err;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack = 0;
   logic [31:0] mem_rdata = 0;

   // 64-bit unit
   logic        w_req_valid = 0, w_req_ready, w_req_is_load = 0;
   logic [2:0]  w_req_funct3 = 0;
   logic [63:0] w_req_addr = 0, w_req_wdata = 0;
   logic        w_resp_valid;
   logic [63:0] w_resp_rdata;
   logic [1:0]  w_resp_err;
   logic        w_mem_req, w_mem_we;
   logic [63:0] w_mem_addr, w_mem_wdata;
   logic [7:0]  w_mem_be;
   logic        w_mem_ack = 0;
   logic [63:0] w_mem_rdata = 0;

   riscv_lsu #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_is_load(req_is_load), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata));

   riscv_lsu #(.XLEN(64), .TIMEOUT_CYCLES(16)) dut64 (
      .clk(clk), .rst(rst), .req_valid(w_req_valid), .req_ready(w_req_ready),
      .req_is_load(w_req_is_load), .req_funct3(w_req_funct3), .req_addr(w_req_addr),
      .req_wdata(w_req_wdata), .resp_valid(w_resp_valid), .resp_rdata(w_resp_rdata),
      .resp_err(w_resp_err), .mem_req(w_mem_req), .mem_we(w_mem_we), .mem_addr(w_mem_addr),
      .mem_be(w_mem_be), .mem_wdata(w_mem_wdata), .mem_ack(w_mem_ack), .mem_rdata(w_mem_rdata));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present a request for one edge; afterwards we are in cycle N+1
   task automatic issue(input logic ld, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
      req_valid = 1; req_is_load = ld; req_funct3 = f3; req_addr = a; req_wdata = wd;
      tick();
      req_valid = 0;
   endtask

   // ack in the current BUSY cycle; afterwards we are in the RESP cycle
   task automatic ack(input logic [31:0] rd);
      mem_ack = 1; mem_rdata = rd;
      tick();
      mem_ack = 0; mem_rdata = 32'h0;
   endtask

   int n;

   initial begin
      tick(); tick();
      // reset state
      chk("rst_ready", req_ready, 1);
      chk("rst_valid", resp_valid, 0);
      chk("rst_err", resp_err, 0);
      chk("rst_rdata", resp_rdata, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_be", mem_be, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      rst = 0;
      tick();

      // LB at 0x103, byte 0x80 sign-extended
      issue(1, 3'b000, 32'h103, 0);
      chk("lb_ready", req_ready, 0);
      chk("lb_mem_req", mem_req, 1);
      chk("lb_mem_we", mem_we, 0);
      chk("lb_mem_be", mem_be, 4'b1000);
      chk("lb_mem_addr", mem_addr, 32'h100);
      ack(32'h80AB_CD12);
      chk("lb_valid", resp_valid, 1);
      chk("lb_rdata", resp_rdata, 32'hFFFF_FF80);
      chk("lb_err", resp_err, 0);
      chk("lb_mem_req_drop", mem_req, 0);
      tick();
      chk("lb_valid_pulse", resp_valid, 0);
      chk("lb_ready_back", req_ready, 1);

      // SH at 0x202
      issue(0, 3'b001, 32'h202, 32'h1234_BEEF);
      chk("sh_mem_be", mem_be, 4'b1100);
      chk("sh_mem_wdata", mem_wdata, 32'hBEEF_BEEF);
      chk("sh_mem_we", mem_we, 1);
      chk("sh_mem_addr", mem_addr, 32'h200);
      ack(32'hDEAD_BEEF);
      chk("sh_valid", resp_valid, 1);
      chk("sh_rdata", resp_rdata, 0);
      chk("sh_err", resp_err, 0);
      tick();

      // SB at 0x1
      issue(0, 3'b000, 32'h1, 32'hABCD_EF55);
      chk("sb_mem_be", mem_be, 4'b0010);
      chk("sb_mem_wdata", mem_wdata, 32'h5555_5555);
      ack(0);
      chk("sb_valid", resp_valid, 1);
      tick();

      // LHU / LH at 0x2
      issue(1, 3'b101, 32'h2, 0);
      chk("lhu_mem_be", mem_be, 4'b1100);
      ack(32'h8001_0000);
      chk("lhu_rdata", resp_rdata, 32'h0000_8001);
      tick();
      issue(1, 3'b001, 32'h2, 0);
      ack(32'h8001_0000);
      chk("lh_rdata", resp_rdata, 32'hFFFF_8001);
      tick();

      // LW at 0x6: misaligned, no memory access, response at N+1
      issue(1, 3'b010, 32'h6, 0);
      chk("mis_valid", resp_valid, 1);
      chk("mis_err", resp_err, 2'b01);
      chk("mis_rdata", resp_rdata, 0);
      chk("mis_mem_req", mem_req, 0);
      tick();
      chk("mis_mem_req2", mem_req, 0);
      chk("mis_valid_pulse", resp_valid, 0);

      // illegal funct3: LD on 32-bit, store 100, illegal beats misaligned
      issue(1, 3'b011, 32'h8, 0);
      chk("ill_ld_valid", resp_valid, 1);
      chk("ill_ld_err", resp_err, 2'b11);
      chk("ill_ld_mem_req", mem_req, 0);
      tick();
      issue(0, 3'b100, 32'h0, 0);
      chk("ill_st_err", resp_err, 2'b11);
      tick();
      issue(1, 3'b111, 32'h1, 0);
      chk("ill_prio_err", resp_err, 2'b11);
      tick();

      // timeout: mem_req high exactly 4 cycles, address stable
      issue(1, 3'b010, 32'h10, 0);
      n = 0;
      for (int i = 0; i < 12 && !resp_valid; i++) begin
         if (mem_req) begin
            n++;
            chk("tmo_addr_stable", mem_addr, 32'h10);
         end
         tick();
      end
      chk("tmo_req_cycles", n, 4);
      chk("tmo_valid", resp_valid, 1);
      chk("tmo_err", resp_err, 2'b10);
      chk("tmo_rdata", resp_rdata, 0);
      chk("tmo_mem_req", mem_req, 0);
      tick();

      // ack in the 4th BUSY cycle wins over the timeout
      issue(1, 3'b010, 32'h10, 0);
      tick(); tick(); tick();
      chk("late4_mem_req", mem_req, 1);
      chk("late4_mem_be", mem_be, 4'b1111);
      ack(32'h1122_3344);
      chk("late4_valid", resp_valid, 1);
      chk("late4_err", resp_err, 0);
      chk("late4_rdata", resp_rdata, 32'h1122_3344);
      tick();

      // reset during BUSY, then a late ack
      issue(1, 3'b010, 32'h20, 0);
      chk("rb_mem_req", mem_req, 1);
      rst = 1;
      tick();
      rst = 0;
      chk("rb_mem_req_drop", mem_req, 0);
      chk("rb_ready", req_ready, 1);
      chk("rb_valid", resp_valid, 0);
      mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
      tick();
      mem_ack = 0;
      chk("rb_late_valid", resp_valid, 0);
      chk("rb_late_ready", req_ready, 1);
      chk("rb_late_mem_req", mem_req, 0);
      tick();
      chk("rb_late_valid2", resp_valid, 0);

      // 64-bit: LD at 0x8 returns the whole word
      w_req_valid = 1; w_req_is_load = 1; w_req_funct3 = 3'b011; w_req_addr = 64'h8;
      tick();
      w_req_valid = 0;
      chk("ld64_mem_be", w_mem_be, 8'hFF);
      chk("ld64_mem_addr", w_mem_addr, 64'h8);
      w_mem_ack = 1; w_mem_rdata = 64'h8000_0000_0000_0001;
      tick();
      w_mem_ack = 0;
      chk("ld64_valid", w_resp_valid, 1);
      chk("ld64_err", w_resp_err, 0);
      chk("ld64_rdata", w_resp_rdata, 64'h8000_0000_0000_0001);
      tick();

      // 64-bit: LW at 0x4 sign-extends the upper word
      w_req_valid = 1; w_req_is_load = 1; w_req_funct3 = 3'b010; w_req_addr = 64'h4;
      tick();
      w_req_valid = 0;
      chk("lw64_mem_be", w_mem_be, 8'hF0);
      w_mem_ack = 1; w_mem_rdata = 64'h89AB_CDEF_0000_0000;
      tick();
      w_mem_ack = 0;
      chk("lw64_rdata", w_resp_rdata, 64'hFFFF_FFFF_89AB_CDEF);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/riscv_lsu.md
RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning data/address width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of cycles spent waiting for mem_ack (range 1..255).
REQ-003 The block SHALL have port clk  input  1  single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid  input  1  request present.
REQ-006 The block SHALL have port req_ready  output  1  block can accept a request.
REQ-007 The block SHALL have port req_is_load  input  1  1=load, 0=store.
REQ-008 The block SHALL have port req_funct3  input  3  RISC-V load/store funct3.
REQ-009 The block SHALL have port req_addr  input  XLEN  byte address.
REQ-010 The block SHALL have port req_wdata  input  XLEN  store data, right-aligned.
REQ-011 The block SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 The block SHALL have port resp_rdata  output  XLEN  extended load data.
REQ-013 The block SHALL have port resp_err  output  2  error code: 00=ok, 01=misaligned, 10=timeout, 11=illegal funct3.
REQ-014 The block SHALL have port mem_req  output  1  memory request, held until ack.
REQ-015 The block SHALL have port mem_we  output  1  1=write.
REQ-016 The block SHALL have port mem_addr  output  XLEN  address aligned to XLEN/8 bytes (low lane bits zeroed).
REQ-017 The block SHALL have port mem_be  output  XLEN/8  byte enables.
REQ-018 The block SHALL have port mem_wdata  output  XLEN  lane-positioned write data.
REQ-019 The block SHALL have port mem_ack  input  1  memory completion.
REQ-020 The block SHALL have port mem_rdata  input  XLEN  read data, valid with mem_ack.

Function
REQ-021 The FSM SHALL have the states IDLE, BUSY and RESP; req_ready SHALL be 1 only in IDLE.
REQ-022 The block SHALL accept a request when req_valid && req_ready and register all req_* fields.
REQ-023 Legal funct3 values SHALL be: loads 000/001/010/100/101, plus 011/110 when XLEN=64; stores 000/001/010, plus 011 when XLEN=64. Any other value SHALL be illegal.
REQ-024 Access size SHALL be 2^funct3[1:0] bytes; an access SHALL be misaligned when req_addr mod size != 0.
REQ-025 An accepted illegal or misaligned request SHALL go IDLE->RESP, assert no mem_req, and set resp_err to 11 or 01 respectively; illegal takes priority over misaligned.
REQ-026 An accepted legal request SHALL go IDLE->BUSY; mem_req SHALL be 1 in the cycle after acceptance.
REQ-027 mem_req, mem_we, mem_addr, mem_be and mem_wdata SHALL stay stable throughout BUSY.
REQ-028 For offset = addr[log2(XLEN/8)-1:0], mem_be SHALL equal ((1<<size)-1)<<offset.
REQ-029 mem_wdata SHALL equal the low size bytes of req_wdata, replicated across all lanes.
REQ-030 In BUSY, mem_ack=1 SHALL move the FSM to RESP with resp_err=00; for a load, the registered result SHALL be mem_rdata>>(8*offset), truncated to size and sign-extended (funct3[2]=0) or zero-extended (funct3[2]=1).
REQ-031 A timeout counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack; reaching TIMEOUT_CYCLES SHALL drop mem_req and go to RESP with resp_err=10, resp_rdata=0.
REQ-032 When ack and timeout occur in the same cycle, ack SHALL win.
REQ-033 mem_ack outside BUSY SHALL be ignored.
REQ-034 RESP SHALL last exactly one cycle with resp_valid=1, then return to IDLE; there is no response backpressure.
REQ-035 For stores and for all error responses, resp_rdata SHALL be 0.
REQ-036 Minimum legal latency SHALL be acceptance at N, mem_ack at N+1, resp_valid at N+2; error latency SHALL be resp_valid at N+1.

Reset
REQ-037 When rst=1 at a clock edge, the state SHALL become IDLE; the next cycle SHALL show req_ready=1, resp_valid=0, resp_err=00, resp_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, and the timeout counter SHALL be 0.
REQ-038 Reset during BUSY SHALL abandon the transaction with no resp_valid, and mem_req SHALL be 0 in the following cycle.

Verification
REQ-039 Scenario: XLEN=32, LB at addr 0x103, mem_rdata=0x80AB_CD12 with ack next cycle -> mem_be=1000, mem_addr=0x100, resp_rdata=0xFFFF_FF80, resp_err=00.
REQ-040 Scenario: SH at 0x202, wdata=0x1234_BEEF -> mem_be=1100, mem_wdata=0xBEEF_BEEF, mem_we=1, resp_rdata=0.
REQ-041 Scenario: LW at 0x0000_0006 -> resp_valid at N+1, resp_err=01, mem_req never asserted.
REQ-042 Scenario: load with funct3=011 at XLEN=32 -> resp_err=11; at XLEN=64, LD at 0x8 with mem_rdata=0x8000_0000_0000_0001 -> resp_rdata equal to mem_rdata.
REQ-043 Scenario: TIMEOUT_CYCLES=4, no ack -> mem_req high for exactly 4 cycles, resp_err=10; in a separate run, ack arriving in the 4th BUSY cycle -> resp_err=00.
REQ-044 Scenario: rst pulsed during BUSY, then a late mem_ack -> no resp_valid, req_ready=1, and the late ack is ignored.
